dmem_access_seq: RTL and testbench

// Load/store sequencer between the MEM pipeline stage and DataMem. Accepts one

---
 rtl/dmem_access_seq.sv | 180 ++++++++++++++++++
 tb/tb_dmem_access_seq.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_seq.sv
// Load/store sequencer between MEM stage and DataMem: LW as two half reads, SB/SH as read-modify-write.
// Optional macro DMEM_SEQ_MISALIGN_TRAP_EN: misaligned requests trap (resp_err) instead of being force-aligned.
module dmem_access_seq #(
   parameter int  MEM_DEPTH = 32,
   parameter int  RD_LAT    = 1,
   localparam int DM_AW     = $clog2(MEM_DEPTH) + 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic             req_we_i,
   input  logic [2:0]       req_funct3_i,
   input  logic [31:0]      req_addr_i,
   input  logic [31:0]      req_wdata_i,
   output logic             resp_valid_o,
   output logic [31:0]      resp_rdata_o,
   output logic             resp_err_o,
   output logic [DM_AW-1:0] dm_rd_addr_o,
   output logic [DM_AW-1:0] dm_wr_addr_o,
   output logic [31:0]      dm_wr_din_o,
   output logic             dm_we_o,
   output logic [2:0]       dm_wr_strb_o,
   input  logic [31:0]      dm_rd_dout_i
);

   typedef enum logic [2:0] {IDLE, RD0, RD1, WR, RESP} state_e;
   localparam logic [1:0] CNT_LAST = 2'(RD_LAT);

   state_e           state_q;
   logic [1:0]       cnt_q;
   logic             op_we_q;
   logic [1:0]       op_sz_q;
   logic [DM_AW-1:0] op_addr_q;
   logic [31:0]      op_wdata_q;
   logic [15:0]      lo_q;
   logic             resp_valid_q, resp_err_q, dm_we_q;
   logic [31:0]      resp_rdata_q, dm_wr_din_q;
   logic [DM_AW-1:0] dm_rd_addr_q, dm_wr_addr_q;
   logic [2:0]       dm_wr_strb_q;

   logic             is_h, is_w, trap_d;
   logic [DM_AW-1:0] addr_d, word_addr_d;
   logic [31:0]      merged_d;
   logic             unused_addr;

   assign unused_addr = &{1'b0, req_addr_i[31:DM_AW]};

   // Request decode; misaligned H/W addresses are force-aligned (only reaches DataMem when not trapping)
   always_comb begin
      is_h   = (req_funct3_i[1:0] == 2'b01);
      is_w   = (req_funct3_i[1:0] == 2'b10);
      addr_d = req_addr_i[DM_AW-1:0];
      if (is_h) addr_d[0] = 1'b0;
      if (is_w) addr_d[1:0] = 2'b00;
      word_addr_d = {addr_d[DM_AW-1:2], 2'b00};
`ifdef DMEM_SEQ_MISALIGN_TRAP_EN
      trap_d = (is_h && req_addr_i[0]) || (is_w && (req_addr_i[1:0] != 2'b00));
`else
      trap_d = 1'b0;
`endif
   end

   // Store lane merge into the word assembled from the two half reads
   always_comb begin
      merged_d = {dm_rd_dout_i[15:0], lo_q};
      if (op_sz_q == 2'b00) begin
         case (op_addr_q[1:0])
            2'b00:   merged_d[7:0]   = op_wdata_q[7:0];
            2'b01:   merged_d[15:8]  = op_wdata_q[7:0];
            2'b10:   merged_d[23:16] = op_wdata_q[7:0];
            default: merged_d[31:24] = op_wdata_q[7:0];
         endcase
      end else if (op_addr_q[1]) begin
         merged_d[31:16] = op_wdata_q[15:0];
      end else begin
         merged_d[15:0] = op_wdata_q[15:0];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         op_we_q      <= 1'b0;
         op_sz_q      <= '0;
         op_addr_q    <= '0;
         op_wdata_q   <= '0;
         lo_q         <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
         dm_rd_addr_q <= '0;
         dm_wr_addr_q <= '0;
         dm_wr_din_q  <= '0;
         dm_we_q      <= 1'b0;
         dm_wr_strb_q <= '0;
      end else begin
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         dm_we_q      <= 1'b0;
         case (state_q)
            IDLE: if (req_valid_i) begin
               op_we_q    <= req_we_i;
               op_sz_q    <= req_funct3_i[1:0];
               op_addr_q  <= addr_d;
               op_wdata_q <= req_wdata_i;
               cnt_q      <= '0;
               if (trap_d) begin
                  state_q      <= RESP;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= 1'b1;
                  resp_rdata_q <= '0;
               end else if (req_we_i && is_w) begin
                  state_q      <= WR;
                  dm_we_q      <= 1'b1;
                  dm_wr_addr_q <= word_addr_d;
                  dm_wr_din_q  <= req_wdata_i;
               end else if (req_we_i || is_w) begin
                  state_q      <= RD0;
                  dm_rd_addr_q <= word_addr_d;
                  dm_wr_strb_q <= 3'b101;
               end else begin
                  state_q      <= RD0;
                  dm_rd_addr_q <= addr_d;
                  dm_wr_strb_q <= req_funct3_i;
               end
            end
            RD0: if (cnt_q == CNT_LAST) begin
               cnt_q <= '0;
               if (!op_we_q && (op_sz_q != 2'b10)) begin
                  state_q      <= RESP;
                  resp_valid_q <= 1'b1;
                  resp_rdata_q <= dm_rd_dout_i;
               end else begin
                  state_q      <= RD1;
                  lo_q         <= dm_rd_dout_i[15:0];
                  dm_rd_addr_q <= {op_addr_q[DM_AW-1:2], 2'b10};
               end
            end else begin
               cnt_q <= cnt_q + 2'd1;
            end
            RD1: if (cnt_q == CNT_LAST) begin
               cnt_q <= '0;
               if (op_we_q) begin
                  state_q      <= WR;
                  dm_we_q      <= 1'b1;
                  dm_wr_addr_q <= {op_addr_q[DM_AW-1:2], 2'b00};
                  dm_wr_din_q  <= merged_d;
               end else begin
                  state_q      <= RESP;
                  resp_valid_q <= 1'b1;
                  resp_rdata_q <= {dm_rd_dout_i[15:0], lo_q};
               end
            end else begin
               cnt_q <= cnt_q + 2'd1;
            end
            WR: begin
               state_q      <= RESP;
               resp_valid_q <= 1'b1;
               resp_rdata_q <= '0;
            end
            RESP:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready_o  = (state_q == IDLE);
   assign resp_valid_o = resp_valid_q;
   assign resp_rdata_o = resp_rdata_q;
   assign resp_err_o   = resp_err_q;
   assign dm_rd_addr_o = dm_rd_addr_q;
   assign dm_wr_addr_o = dm_wr_addr_q;
   assign dm_wr_din_o  = dm_wr_din_q;
   // A reset arriving during WR must still suppress the write at that edge
   assign dm_we_o      = dm_we_q & ~rst_i;
   assign dm_wr_strb_o = dm_wr_strb_q;

endmodule

// File: tb/tb_dmem_access_seq.sv
// Directed bench for dmem_access_seq (MEM_DEPTH=32, RD_LAT=1) against a byte-addressed DataMem model.
module tb_dmem_access_seq;
   localparam int AW = 7;

   logic          clk = 1'b0, rst = 1'b1;
   logic          req_valid = 1'b0, req_we = 1'b0;
   logic [2:0]    req_funct3 = '0;
   logic [31:0]   req_addr = '0, req_wdata = '0;
   logic          req_ready, resp_valid, resp_err, dm_we;
   logic [31:0]   resp_rdata, dm_wr_din;
   logic [AW-1:0] dm_rd_addr, dm_wr_addr;
   logic [2:0]    dm_wr_strb;
   logic [31:0]   rd_q = '0;

   dmem_access_seq #(.MEM_DEPTH(32), .RD_LAT(1)) dut (
      .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_we_i(req_we), .req_funct3_i(req_funct3), .req_addr_i(req_addr),
      .req_wdata_i(req_wdata), .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata),
      .resp_err_o(resp_err), .dm_rd_addr_o(dm_rd_addr), .dm_wr_addr_o(dm_wr_addr),
      .dm_wr_din_o(dm_wr_din), .dm_we_o(dm_we), .dm_wr_strb_o(dm_wr_strb),
      .dm_rd_dout_i(rd_q)
   );

   always #5 clk = ~clk;

   // DataMem model: one-cycle read latency, extended reads, whole-word writes
   logic [7:0] mem [0:127] = '{default: 8'h00};
   int cyc = 0;

   function automatic logic [31:0] mem_rd(input logic [AW-1:0] a, input logic [2:0] m);
      logic [7:0] b0, b1;
      b0 = mem[a];
      b1 = mem[a + 7'd1];
      case (m)
         3'b000:  return {{24{b0[7]}}, b0};
         3'b100:  return {24'h0, b0};
         3'b001:  return {{16{b1[7]}}, b1, b0};
         3'b101:  return {16'h0, b1, b0};
         default: return 32'h0;
      endcase
   endfunction

   always @(posedge clk) begin
      cyc  <= cyc + 1;
      rd_q <= mem_rd(dm_rd_addr, dm_wr_strb);
      if (dm_we) begin
         mem[dm_wr_addr]         <= dm_wr_din[7:0];
         mem[dm_wr_addr + 7'd1]  <= dm_wr_din[15:8];
         mem[dm_wr_addr + 7'd2]  <= dm_wr_din[23:16];
         mem[dm_wr_addr + 7'd3]  <= dm_wr_din[31:24];
      end
   end

   int            we_cnt = 0, we_cyc = 0;
   logic [AW-1:0] we_addr = '0;
   logic [31:0]   we_din = '0;
   always @(negedge clk) if (dm_we) begin
      we_cnt  <= we_cnt + 1;
      we_cyc  <= cyc;
      we_addr <= dm_wr_addr;
      we_din  <= dm_wr_din;
   end

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          lat;
      logic [31:0] rdata;
      logic        err;
      int          nwe;
      logic [6:0]  waddr;
      logic [31:0] wdin;
   } vec_t;
   vec_t vt[$];

   int            nvec = 0, nerr = 0, t_acc = 0;
   logic [AW-1:0] ra [0:15];
   logic [2:0]    rs [0:15];

   function automatic void add(input logic we, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] d, input int lat, input logic [31:0] rdat,
                               input logic err, input int nwe, input logic [6:0] wa,
                               input logic [31:0] wd);
      vec_t v;
      v.we = we; v.f3 = f3; v.addr = a; v.wdata = d; v.lat = lat;
      v.rdata = rdat; v.err = err; v.nwe = nwe; v.waddr = wa; v.wdin = wd;
      vt.push_back(v);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d);
      @(negedge clk);
      chk("ready before issue", 32'(req_ready), 32'h1);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
      t_acc = cyc;
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_resp(output int lat, output logic [31:0] rd, output logic er);
      lat = -1; rd = '0; er = 1'b0;
      for (int k = 1; k < 16; k++) begin
         @(negedge clk);
         ra[k] = dm_rd_addr;
         rs[k] = dm_wr_strb;
         if (resp_valid) begin
            lat = cyc - t_acc; rd = resp_rdata; er = resp_err;
            break;
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat, w0, t0, acc2, nresp;
      int          rc [0:1];
      logic [31:0] rdv [0:1];
      logic [31:0] rd;
      logic        er;

      //  we  f3      addr          wdata          lat rdata          err nwe waddr  wdin
      add(1, 3'b010, 32'h08,       32'hDEADBEEF,  2, 32'h0,         0,  1, 7'h08, 32'hDEADBEEF);
      add(0, 3'b000, 32'h0B,       32'h0,         3, 32'hFFFFFFDE,  0,  0, 7'h00, 32'h0);
      add(0, 3'b100, 32'h0B,       32'h0,         3, 32'h000000DE,  0,  0, 7'h00, 32'h0);
      add(0, 3'b010, 32'h08,       32'h0,         5, 32'hDEADBEEF,  0,  0, 7'h00, 32'h0);
      add(0, 3'b001, 32'h0A,       32'h0,         3, 32'hFFFFDEAD,  0,  0, 7'h00, 32'h0);
      add(0, 3'b101, 32'h08,       32'h0,         3, 32'h0000BEEF,  0,  0, 7'h00, 32'h0);
      add(1, 3'b000, 32'h09,       32'hFFFFFF55,  6, 32'h0,         0,  1, 7'h08, 32'hDEAD55EF);
      add(0, 3'b010, 32'h08,       32'h0,         5, 32'hDEAD55EF,  0,  0, 7'h00, 32'h0);
      add(1, 3'b001, 32'h0E,       32'h00001234,  6, 32'h0,         0,  1, 7'h0C, 32'h12340000);
      add(1, 3'b000, 32'h0C,       32'h000000A5,  6, 32'h0,         0,  1, 7'h0C, 32'h123400A5);
      add(0, 3'b000, 32'h0C,       32'h0,         3, 32'hFFFFFFA5,  0,  0, 7'h00, 32'h0);
      add(0, 3'b001, 32'h0E,       32'h0,         3, 32'h00001234,  0,  0, 7'h00, 32'h0);
      add(0, 3'b100, 32'h0F,       32'h0,         3, 32'h00000012,  0,  0, 7'h00, 32'h0);
      add(1, 3'b010, 32'h7C,       32'h01020304,  2, 32'h0,         0,  1, 7'h7C, 32'h01020304);
      add(1, 3'b000, 32'hFFFFFF7F, 32'h00000080,  6, 32'h0,         0,  1, 7'h7C, 32'h80020304);
      add(0, 3'b010, 32'h0000007C, 32'h0,         5, 32'h80020304,  0,  0, 7'h00, 32'h0);
      add(0, 3'b000, 32'h7F,       32'h0,         3, 32'hFFFFFF80,  0,  0, 7'h00, 32'h0);
      add(0, 3'b000, 32'h09,       32'h0,         3, 32'h00000055,  0,  0, 7'h00, 32'h0);
`ifdef DMEM_SEQ_MISALIGN_TRAP_EN
      add(1, 3'b001, 32'h0B,       32'h0000BEEF,  1, 32'h0,         1,  0, 7'h00, 32'h0);
      add(0, 3'b010, 32'h0A,       32'h0,         1, 32'h0,         1,  0, 7'h00, 32'h0);
      add(0, 3'b101, 32'h09,       32'h0,         1, 32'h0,         1,  0, 7'h00, 32'h0);
      add(1, 3'b010, 32'h0D,       32'h11223344,  1, 32'h0,         1,  0, 7'h00, 32'h0);
      add(0, 3'b010, 32'h0C,       32'h0,         5, 32'h123400A5,  0,  0, 7'h00, 32'h0);
`else
      add(1, 3'b001, 32'h0B,       32'h0000BEEF,  6, 32'h0,         0,  1, 7'h08, 32'hBEEF55EF);
      add(0, 3'b010, 32'h0A,       32'h0,         5, 32'hBEEF55EF,  0,  0, 7'h00, 32'h0);
      add(0, 3'b101, 32'h09,       32'h0,         3, 32'h000055EF,  0,  0, 7'h00, 32'h0);
      add(1, 3'b010, 32'h0D,       32'h11223344,  2, 32'h0,         0,  1, 7'h0C, 32'h11223344);
      add(0, 3'b010, 32'h0C,       32'h0,         5, 32'h11223344,  0,  0, 7'h00, 32'h0);
`endif

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst req_ready",  32'(req_ready),  32'h1);
      chk("rst resp_valid", 32'(resp_valid), 32'h0);
      chk("rst resp_rdata", resp_rdata,      32'h0);
      chk("rst resp_err",   32'(resp_err),   32'h0);
      chk("rst dm_we",      32'(dm_we),      32'h0);
      chk("rst dm_rd_addr", 32'(dm_rd_addr), 32'h0);
      chk("rst dm_wr_addr", 32'(dm_wr_addr), 32'h0);
      chk("rst dm_wr_din",  dm_wr_din,       32'h0);
      chk("rst dm_wr_strb", 32'(dm_wr_strb), 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      foreach (vt[i]) begin
         w0 = we_cnt;
         issue(vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata);
         wait_resp(lat, rd, er);
         chk($sformatf("v%0d latency", i), 32'(lat), 32'(vt[i].lat));
         chk($sformatf("v%0d rdata", i), rd, vt[i].rdata);
         chk($sformatf("v%0d err", i), 32'(er), 32'(vt[i].err));
         chk($sformatf("v%0d write count", i), 32'(we_cnt - w0), 32'(vt[i].nwe));
         if (vt[i].nwe == 1 && we_cnt - w0 == 1) begin
            chk($sformatf("v%0d write cycle", i), 32'(we_cyc - t_acc), 32'(vt[i].lat - 1));
            chk($sformatf("v%0d wr_addr", i), 32'(we_addr), 32'(vt[i].waddr));
            chk($sformatf("v%0d wr_din", i), we_din, vt[i].wdin);
         end
      end

      // LW read sequence: aligned word address then +2, strb 101, address held through the state
      issue(1'b0, 3'b010, 32'h08, 32'h0);
      wait_resp(lat, rd, er);
      chk("lw latency",       32'(lat),   32'd5);
      chk("lw rd_addr T+1",   32'(ra[1]), 32'h08);
      chk("lw rd_addr T+2",   32'(ra[2]), 32'h08);
      chk("lw strb T+1",      32'(rs[1]), 32'h5);
      chk("lw rd_addr T+3",   32'(ra[3]), 32'h0A);
      chk("lw strb T+3",      32'(rs[3]), 32'h5);
`ifdef DMEM_SEQ_MISALIGN_TRAP_EN
      chk("lw rdata",         rd,         32'hDEAD55EF);
`else
      chk("lw rdata",         rd,         32'hBEEF55EF);
`endif

      // Back-to-back: SW then LW held valid while busy; LW accepted the cycle after RESP
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h10;
      req_wdata = 32'hCAFEF00D;
      t0 = cyc;
      @(posedge clk); #1;
      req_we = 1'b0; req_wdata = 32'h0;
      acc2 = -1; nresp = 0; rc[0] = -1; rc[1] = -1; rdv[0] = '0; rdv[1] = '0;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         if (resp_valid && nresp < 2) begin
            rc[nresp] = cyc - t0; rdv[nresp] = resp_rdata; nresp++;
         end
         if (req_valid && req_ready) begin
            acc2 = cyc - t0;
            @(posedge clk); #1;
            req_valid = 1'b0;
         end
      end
      chk("b2b responses",   32'(nresp), 32'd2);
      chk("b2b sw resp",     32'(rc[0]), 32'd2);
      chk("b2b lw accept",   32'(acc2),  32'd3);
      chk("b2b lw resp",     32'(rc[1]), 32'd8);
      chk("b2b lw rdata",    rdv[1],     32'hCAFEF00D);

      // Reset during RD1 of an SB: no write, ready right after release
      issue(1'b1, 3'b000, 32'h11, 32'h77);
      w0 = we_cnt;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("rst-rd1 ready", 32'(req_ready), 32'h1);
      repeat (8) @(posedge clk);
      chk("rst-rd1 no write", 32'(we_cnt - w0), 32'h0);

      // Reset asserted in the WR cycle of an SH: the write must not happen
      issue(1'b1, 3'b001, 32'h12, 32'h9999);
      w0 = we_cnt;
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      repeat (8) @(posedge clk);
      chk("rst-wr no write", 32'(we_cnt - w0), 32'h0);

      issue(1'b0, 3'b010, 32'h10, 32'h0);
      wait_resp(lat, rd, er);
      chk("post-rst lw latency", 32'(lat), 32'd5);
      chk("post-rst lw rdata",   rd,       32'hCAFEF00D);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
